pipeline_run_ctrl: RTL and testbench

//  Run controller for the pipelined core(s): sequences core reset release, counts run cycles,
//  and ends the run on halt, global cycle limit or per-core retire watchdog.

---
 rtl/pipeline_run_ctrl.sv | 172 +++++++++++++++++
 tb/tb_pipeline_run_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_run_ctrl.sv
// Run controller: core reset sequencing, run-cycle count, halt/limit/watchdog end.
// Optional RUN_CTRL_RETIRE_CNT_EN adds per-core retired-instruction counters.
module pipeline_run_ctrl #(
  parameter int N_CORES         = 1,
  parameter int RST_HOLD_CYCLES = 4,
  parameter int CYC_W           = 32,
  parameter int MAX_CYCLES      = 10000,
  parameter int WDOG_CYCLES     = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run_en,
  input  logic [N_CORES-1:0] halt,
  input  logic [N_CORES-1:0] retire,
  output logic [N_CORES-1:0] core_rst_n,
  output logic               core_stall,
  output logic [CYC_W-1:0]   cycle_cnt,
  output logic               done,
  output logic               timeout,
  output logic [N_CORES-1:0] wdog_trip
`ifdef RUN_CTRL_RETIRE_CNT_EN
  ,
  output logic [N_CORES*CYC_W-1:0] retire_cnt
`endif
);

  localparam int HW = $clog2(RST_HOLD_CYCLES + 1);
  localparam int WW = $clog2(WDOG_CYCLES);

  localparam logic [HW-1:0] HOLD_LAST =
    HW'(RST_HOLD_CYCLES - 1);
  localparam logic [WW-1:0] WDOG_LAST =
    WW'(WDOG_CYCLES - 1);
  localparam logic [CYC_W-1:0] CYC_LAST =
    CYC_W'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {
    S_HOLD,
    S_RUN,
    S_DONE,
    S_TMO
  } state_t;

  state_t state, state_d;

  logic                        run_q;
  logic [HW-1:0]               hold_cnt, hold_d;
  logic [CYC_W-1:0]            cyc_d;
  logic [N_CORES-1:0]          halted_q, halted_d;
  logic [N_CORES-1:0][WW-1:0]  wdog_q, wdog_d;
  logic [N_CORES-1:0]          rstn_d, trip_d;
  logic                        stall_d, done_d, tmo_d;
  logic [N_CORES-1:0]          halt_all, trip_now;
  logic                        live_edge;

  assign halt_all = halted_q | halt;

  always_comb begin
    trip_now = '0;
    for (int i = 0; i < N_CORES; i++) begin
      trip_now[i] = !halt_all[i] && !retire[i]
                    && (wdog_q[i] == WDOG_LAST);
    end
  end

  always_comb begin
    state_d   = state;
    hold_d    = hold_cnt;
    cyc_d     = cycle_cnt;
    halted_d  = halted_q;
    wdog_d    = wdog_q;
    rstn_d    = core_rst_n;
    stall_d   = core_stall;
    done_d    = done;
    tmo_d     = timeout;
    trip_d    = wdog_trip;
    live_edge = 1'b0;
    unique case (state)
      S_HOLD: begin
        // run_q delays the count by one edge: "run_en seen high"
        if (run_q) begin
          if (hold_cnt == HOLD_LAST) begin
            state_d = S_RUN;
            rstn_d  = '1;
            stall_d = 1'b0;
          end else begin
            hold_d = hold_cnt + HW'(1);
          end
        end
      end
      S_RUN: begin
        stall_d   = ~run_en;
        live_edge = run_en;
        if (run_en) begin
          if (&halt_all) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            stall_d = 1'b1;
          end else if ((cycle_cnt == CYC_LAST)
                       || (|trip_now)) begin
            state_d = S_TMO;
            tmo_d   = 1'b1;
            stall_d = 1'b1;
            trip_d  = wdog_trip | trip_now;
          end else begin
            cyc_d    = cycle_cnt + CYC_W'(1);
            halted_d = halt_all;
            for (int i = 0; i < N_CORES; i++) begin
              if (retire[i])
                wdog_d[i] = '0;
              else if (!halted_q[i])
                wdog_d[i] = wdog_q[i] + WW'(1);
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_HOLD;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q      <= 1'b0;
      hold_cnt   <= '0;
      cycle_cnt  <= '0;
      halted_q   <= '0;
      wdog_q     <= '0;
      core_rst_n <= '0;
      core_stall <= 1'b1;
      done       <= 1'b0;
      timeout    <= 1'b0;
      wdog_trip  <= '0;
    end else begin
      run_q      <= run_en;
      hold_cnt   <= hold_d;
      cycle_cnt  <= cyc_d;
      halted_q   <= halted_d;
      wdog_q     <= wdog_d;
      core_rst_n <= rstn_d;
      core_stall <= stall_d;
      done       <= done_d;
      timeout    <= tmo_d;
      wdog_trip  <= trip_d;
    end
  end

`ifdef RUN_CTRL_RETIRE_CNT_EN
  logic [N_CORES-1:0][CYC_W-1:0] rcnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rcnt_q <= '0;
    end else if (live_edge) begin
      for (int i = 0; i < N_CORES; i++) begin
        if (retire[i] && !(&rcnt_q[i]))
          rcnt_q[i] <= rcnt_q[i] + CYC_W'(1);
      end
    end
  end

  assign retire_cnt = rcnt_q;
`else
  logic unused_live;
  assign unused_live = live_edge;
`endif

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Randomized + directed bench for pipeline_run_ctrl against a
// cycle-level behavioural model (N_CORES=2, hold 4, limit 100, wdog 8).
module tb_pipeline_run_ctrl;

  localparam int N  = 2;
  localparam int RH = 4;
  localparam int CW = 32;
  localparam int MC = 100;
  localparam int WD = 8;

  logic          clk;
  logic          reset;
  logic          run_en;
  logic [N-1:0]  halt;
  logic [N-1:0]  retire;
  logic [N-1:0]  core_rst_n;
  logic          core_stall;
  logic [CW-1:0] cycle_cnt;
  logic          done;
  logic          timeout;
  logic [N-1:0]  wdog_trip;
`ifdef RUN_CTRL_RETIRE_CNT_EN
  logic [N*CW-1:0] retire_cnt;
`endif

  pipeline_run_ctrl #(
    .N_CORES(N),
    .RST_HOLD_CYCLES(RH),
    .CYC_W(CW),
    .MAX_CYCLES(MC),
    .WDOG_CYCLES(WD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .run_en(run_en),
    .halt(halt),
    .retire(retire),
    .core_rst_n(core_rst_n),
    .core_stall(core_stall),
    .cycle_cnt(cycle_cnt),
    .done(done),
    .timeout(timeout),
    .wdog_trip(wdog_trip)
`ifdef RUN_CTRL_RETIRE_CNT_EN
    ,
    .retire_cnt(retire_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // behavioural model: what the bench expects to see
  bit       m_live;
  bit       m_done;
  bit       m_tmo;
  bit       m_stall;
  int       m_seen;
  int       m_cyc;
  bit [1:0] m_halted;
  bit [1:0] m_trip;
  int       m_idle [N];
  int       m_ret  [N];

  task automatic model_reset();
    m_live   = 0;
    m_done   = 0;
    m_tmo    = 0;
    m_stall  = 1;
    m_seen   = 0;
    m_cyc    = 0;
    m_halted = '0;
    m_trip   = '0;
    for (int i = 0; i < N; i++) begin
      m_idle[i] = 0;
      m_ret[i]  = 0;
    end
  endtask

  task automatic model_edge();
    bit [1:0] hs;
    bit [1:0] tr;
    if (!m_live) begin
      if (run_en) m_seen++;
      if (m_seen == RH + 1) begin
        m_live  = 1;
        m_stall = 0;
      end
    end else if (!m_done && !m_tmo) begin
      m_stall = !run_en;
      if (run_en) begin
        for (int i = 0; i < N; i++)
          if (retire[i]) m_ret[i]++;
        hs = m_halted | halt;
        tr = '0;
        for (int i = 0; i < N; i++)
          if (!hs[i] && !retire[i] && m_idle[i] == WD - 1)
            tr[i] = 1;
        if (hs == 2'b11) begin
          m_done  = 1;
          m_stall = 1;
        end else if (m_cyc == MC - 1 || tr != 0) begin
          m_tmo   = 1;
          m_stall = 1;
          m_trip  = m_trip | tr;
        end else begin
          m_cyc++;
          for (int i = 0; i < N; i++) begin
            if (retire[i])        m_idle[i] = 0;
            else if (!m_halted[i]) m_idle[i]++;
          end
          m_halted = hs;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rstn"}, core_rst_n, m_live ? 2'b11 : 2'b00);
    chk({tag, ".stall"}, core_stall, m_stall);
    chk({tag, ".cyc"}, cycle_cnt, m_cyc);
    chk({tag, ".done"}, done, m_done);
    chk({tag, ".tmo"}, timeout, m_tmo);
    chk({tag, ".trip"}, wdog_trip, m_trip);
`ifdef RUN_CTRL_RETIRE_CNT_EN
    chk({tag, ".rc0"}, retire_cnt[CW-1:0], m_ret[0]);
    chk({tag, ".rc1"}, retire_cnt[2*CW-1:CW], m_ret[1]);
`endif
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    #($urandom_range(0, 2));
    reset  = 1'b0;
    run_en = 1'b0;
    halt   = '0;
    retire = '0;
    model_reset();
    #1;
    check_all({tag, ".async"});
    chk({tag, ".r_rstn"}, core_rst_n, 2'b00);
    chk({tag, ".r_stall"}, core_stall, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check_all({tag, ".held"});
    reset = 1'b1;
  endtask

  task automatic release_cores(input string tag);
    run_en = 1'b1;
    for (int k = 1; k <= RH + 1; k++) begin
      step(tag);
      chk({tag, ".lat"}, core_rst_n,
          (k == RH + 1) ? 2'b11 : 2'b00);
    end
    chk({tag, ".cyc0"}, cycle_cnt, 0);
  endtask

  function automatic bit ended();
    return m_done || m_tmo;
  endfunction

  initial begin
    reset  = 1'b1;
    run_en = 1'b0;
    halt   = '0;
    retire = '0;
    #1;

    // staggered halts end the run with done
    do_reset("s1");
    release_cores("s1");
    for (int n = 0; n < 200 && !ended(); n++) begin
      retire  = (m_cyc % 3 == 0) ? 2'b11 : 2'b00;
      halt[0] = (m_cyc >= 20);
      halt[1] = (m_cyc >= 35);
      step("s1");
    end
    chk("s1.done", done, 1);
    chk("s1.cyc", cycle_cnt, 35);
    chk("s1.stall", core_stall, 1);
    chk("s1.tmo", timeout, 0);
    for (int n = 0; n < 6; n++) begin
      run_en = 1'($urandom);
      halt   = 2'($urandom);
      retire = 2'($urandom);
      step("s1t");
    end
    chk("s1.frozen", cycle_cnt, 35);

    // core 1 goes silent -> watchdog
    do_reset("s2");
    release_cores("s2");
    for (int n = 0; n < 200 && !ended(); n++) begin
      retire[0] = (m_cyc % 3 == 0);
      retire[1] = (m_cyc % 3 == 0) && (m_cyc < 10);
      step("s2");
    end
    chk("s2.trip", wdog_trip, 2'b10);
    chk("s2.tmo", timeout, 1);
    chk("s2.cyc", cycle_cnt, 17);
    chk("s2.done", done, 0);

    // no halt -> global limit
    do_reset("s3");
    release_cores("s3");
    for (int n = 0; n < 200 && !ended(); n++) begin
      retire = (m_cyc % 3 == 0) ? 2'b11 : 2'b00;
      step("s3");
    end
    chk("s3.tmo", timeout, 1);
    chk("s3.cyc", cycle_cnt, 99);
    chk("s3.trip", wdog_trip, 2'b00);
    chk("s3.done", done, 0);

    // pause mid-run
    do_reset("s4");
    release_cores("s4");
    for (int n = 0; n < 100 && m_cyc < 30; n++) begin
      retire = (m_cyc % 2 == 0) ? 2'b11 : 2'b00;
      step("s4");
    end
    run_en = 1'b0;
    for (int n = 0; n < 10; n++) begin
      retire = 2'($urandom);
      step("s4p");
    end
    chk("s4.pcyc", cycle_cnt, 30);
    chk("s4.pstall", core_stall, 1);
    run_en = 1'b1;
    for (int n = 0; n < 5; n++) begin
      retire = (m_cyc % 2 == 0) ? 2'b11 : 2'b00;
      step("s4r");
    end
    chk("s4.rcyc", cycle_cnt, 35);
    chk("s4.rstall", core_stall, 0);

    // last halt on the limit edge: done wins
    do_reset("s5");
    release_cores("s5");
    for (int n = 0; n < 200 && !ended(); n++) begin
      retire  = (m_cyc % 3 == 0) ? 2'b11 : 2'b00;
      halt[0] = (m_cyc >= 50);
      halt[1] = (m_cyc >= 99);
      step("s5");
    end
    chk("s5.done", done, 1);
    chk("s5.tmo", timeout, 0);
    chk("s5.cyc", cycle_cnt, 99);
    do_reset("s5r");
    chk("s5r.cyc", cycle_cnt, 0);
    chk("s5r.done", done, 0);
    chk("s5r.tmo", timeout, 0);
    chk("s5r.trip", wdog_trip, 0);

    // random traffic, some runs cut short by reset
    for (int t = 0; t < 9; t++) begin
      int pct;
      int len;
      pct = (t % 3 == 0) ? 60 : ((t % 3 == 1) ? 25 : 12);
      len = (t % 2 == 0) ? 250 : $urandom_range(5, 60);
      do_reset("rnd");
      release_cores("rnd");
      for (int n = 0; n < len && !ended(); n++) begin
        run_en    = ($urandom_range(0, 7) != 0);
        retire[0] = ($urandom_range(0, 99) < pct);
        retire[1] = ($urandom_range(0, 99) < pct);
        halt[0]   = halt[0] | ($urandom_range(0, 79) == 0);
        halt[1]   = halt[1] | ($urandom_range(0, 79) == 0);
        step("rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
